// File: rtl/registers_fp_pkg.sv
// Shared widths and types for the floating-point register file.
package registers_fp_pkg;

  localparam int FP_REG_ADDR_W = 5;
  localparam int FP_REG_DATA_W = 32;

  typedef logic [FP_REG_ADDR_W-1:0] fp_reg_idx_t;
  typedef logic [FP_REG_DATA_W-1:0] fp_word_t;

endpackage

// File: rtl/registers_fp.sv
// FP register file f0-f31: two combinational read ports, one write port committed on the rising edge.
// Reads have zero latency with no bypass; writes are visible after one edge; no backpressure.
module registers_fp
  import registers_fp_pkg::*;
#(
  parameter int DATA_WIDTH = FP_REG_DATA_W,
  parameter int ADDR_WIDTH = FP_REG_ADDR_W,
  parameter int NUM_REGS   = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] readRegister1,
  input  logic [ADDR_WIDTH-1:0] readRegister2,
  input  logic [ADDR_WIDTH-1:0] writeRegister,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic                  regWrite,
  output logic [DATA_WIDTH-1:0] readData1,
  output logic [DATA_WIDTH-1:0] readData2
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  // f0 is an ordinary register here, unlike the integer file's x0.
  always_comb begin
    regs_d = regs_q;
    if (regWrite) begin
      regs_d[writeRegister] = writeData;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  assign readData1 = regs_q[readRegister1];
  assign readData2 = regs_q[readRegister2];

endmodule

// File: tb/tb_registers_fp.sv
// Directed bench for registers_fp: reset, write/read, write disable, f0, read-during-write, reset priority.
module tb_registers_fp;

  logic        clk;
  logic        reset;
  logic [4:0]  readRegister1;
  logic [4:0]  readRegister2;
  logic [4:0]  writeRegister;
  logic [31:0] writeData;
  logic        regWrite;
  logic [31:0] readData1;
  logic [31:0] readData2;

  int total = 0;
  int bad   = 0;

  registers_fp dut (
    .clk           (clk),
    .reset         (reset),
    .readRegister1 (readRegister1),
    .readRegister2 (readRegister2),
    .writeRegister (writeRegister),
    .writeData     (writeData),
    .regWrite      (regWrite),
    .readData1     (readData1),
    .readData2     (readData2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and leave 1 time unit of settling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
    readRegister1 = a1;
    readRegister2 = a2;
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    regWrite      = 1'b1;
    writeRegister = a;
    writeData     = d;
    tick();
    regWrite      = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    regWrite      = 1'b0;
    writeRegister = '0;
    writeData     = '0;
    readRegister1 = '0;
    readRegister2 = '0;
    tick();
    reset = 1'b0;

    // 1. reset state
    rd(5'd1, 5'd2);   chk("rst_r1_f1", readData1, 32'h0);  chk("rst_r2_f2", readData2, 32'h0);
    rd(5'd0, 5'd31);  chk("rst_r1_f0", readData1, 32'h0);  chk("rst_r2_f31", readData2, 32'h0);
    rd(5'd15, 5'd16); chk("rst_r1_f15", readData1, 32'h0); chk("rst_r2_f16", readData2, 32'h0);

    // 2. basic write/read on consecutive edges
    regWrite = 1'b1; writeRegister = 5'd1; writeData = 32'd1;
    tick();
    writeRegister = 5'd2; writeData = 32'd1;
    tick();
    regWrite = 1'b0;
    rd(5'd1, 5'd2);
    chk("basic_f1", readData1, 32'd1);
    chk("basic_f2", readData2, 32'd1);
    for (int i = 3; i < 32; i++) begin
      rd(5'(i), 5'd0);
      chk($sformatf("basic_untouched_f%0d", i), readData1, 32'h0);
    end
    chk("basic_untouched_f0", readData2, 32'h0);

    // 3. write disabled
    regWrite = 1'b0; writeRegister = 5'd3; writeData = 32'hDEADBEEF;
    tick(); tick(); tick();
    rd(5'd3, 5'd3);
    chk("wdis_f3_p1", readData1, 32'h0);
    chk("wdis_f3_p2", readData2, 32'h0);

    // 4. f0 writable, dual port
    wr(5'd0, 32'h3F800000);
    wr(5'd31, 32'hC0000000);
    rd(5'd0, 5'd31);
    chk("f0_val", readData1, 32'h3F800000);
    chk("f31_val", readData2, 32'hC0000000);
    rd(5'd31, 5'd31);
    chk("dual_f31_p1", readData1, 32'hC0000000);
    chk("dual_f31_p2", readData2, 32'hC0000000);

    // 5. read during write: old value before the edge, new after
    wr(5'd5, 32'hA);
    rd(5'd5, 5'd5);
    regWrite = 1'b1; writeRegister = 5'd5; writeData = 32'hB;
    #1;
    chk("rdw_before", readData1, 32'hA);
    tick();
    regWrite = 1'b0;
    chk("rdw_after", readData1, 32'hB);

    // back-to-back writes to one address keep the last
    regWrite = 1'b1; writeRegister = 5'd9; writeData = 32'h1111;
    tick();
    writeData = 32'h2222;
    tick();
    regWrite = 1'b0;
    rd(5'd9, 5'd8);
    chk("b2b_f9", readData1, 32'h2222);
    chk("b2b_f8_untouched", readData2, 32'h0);

    // 6. fill f1..f31 with i, then reset with a simultaneous write
    for (int i = 1; i < 32; i++) wr(5'(i), 32'(i));
    rd(5'd7, 5'd30);
    chk("fill_f7", readData1, 32'd7);
    chk("fill_f30", readData2, 32'd30);
    reset = 1'b1; regWrite = 1'b1; writeRegister = 5'd7; writeData = 32'hFFFFFFFF;
    tick();
    reset = 1'b0; regWrite = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rd(5'(i), 5'(31 - i));
      chk($sformatf("rstprio_f%0d", i), readData1, 32'h0);
    end
    wr(5'd7, 32'h55);
    rd(5'd7, 5'd8);
    chk("post_rst_f7", readData1, 32'h55);
    chk("post_rst_f8", readData2, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
